// File: rtl/cpu_tick_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_tick_pkg
// Description : Shared state encoding for the CPU run/halt/step controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_tick_pkg;

  // Controller state, encoded as it appears on the state output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_tick_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_tick_ctrl_if
// Description : Control inputs and tick/status outputs of the CPU tick
//               controller. The board side drives through master; the
//               controller connects through slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_tick_ctrl_if #(
  parameter int TICK_W = 32
);
  logic              set_freq;
  logic              run_req;
  logic              step_btn;
  logic              halt_in;
  logic              resume;
  logic              cpu_tick;
  logic              cpu_clk_led;
  logic [1:0]        state;
  logic [TICK_W-1:0] tick_count;

  modport master (
    output set_freq, run_req, step_btn, halt_in, resume,
    input  cpu_tick, cpu_clk_led, state, tick_count
  );

  modport slave (
    input  set_freq, run_req, step_btn, halt_in, resume,
    output cpu_tick, cpu_clk_led, state, tick_count
  );
endinterface
`default_nettype wire

// File: rtl/cpu_tick_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, stability-counter debounce and
//               rising-edge pulse for a raw pushbutton.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DBNC_CYC = 50000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic btn,
  output logic      pulse
);
  localparam int c_cw = (DBNC_CYC < 2) ? 1 : $clog2(DBNC_CYC + 1);
  localparam logic [c_cw-1:0] c_last = c_cw'(DBNC_CYC - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic [c_cw-1:0] r_cnt;
  logic            r_pulse;
  logic            w_differ;
  logic            w_accept;

  assign w_differ = (r_sync2 != r_level);
  assign w_accept = w_differ && (r_cnt == c_last);

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed for DBNC_CYC cycles in a row;
  // any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_accept && r_sync2;
      if (!w_differ || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_level <= r_sync2;
      end
    end
  end

  assign pulse = r_pulse;
endmodule
`default_nettype wire

// File: rtl/cpu_tick_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_tick_ctrl
// Description : Run/halt/single-step controller producing the one-cycle
//               cpu_tick enable from a programmable divider.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_tick_ctrl
  import cpu_tick_pkg::*;
#(
  parameter int FAST_DIV = 250000,
  parameter int SLOW_DIV = 25000000,
  parameter int CNT_W    = 25,
  parameter int DBNC_CYC = 50000,
  parameter int TICK_W   = 32
) (
  input wire logic     clk,
  input wire logic     reset,
  cpu_tick_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] c_fast_m1 = CNT_W'(FAST_DIV - 1);
  localparam logic [CNT_W-1:0] c_slow_m1 = CNT_W'(SLOW_DIV - 1);

  state_t            r_state;
  state_t            r_ret;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_halt_q;
  logic              r_led;
  logic [TICK_W-1:0] r_tick_count;

  logic              w_step_pulse;
  logic [CNT_W-1:0]  w_div_m1;
  logic              w_tc;
  logic              w_halt_rise;
  logic              w_tick;
  logic              w_cnt_clr;

  btn_debounce #(
    .DBNC_CYC (DBNC_CYC)
  ) u_step_dbnc (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.step_btn),
    .pulse (w_step_pulse)
  );

  // The >= compare lets a mid-count switch to a shorter period fire at once.
  assign w_div_m1    = bus.set_freq ? c_fast_m1 : c_slow_m1;
  assign w_tc        = (r_state == ST_RUN) && (r_cnt >= w_div_m1);
  assign w_halt_rise = bus.halt_in & ~r_halt_q;

  // Leaving RUN this cycle clears the counter too, so it sits at 0 outside RUN.
  assign w_cnt_clr = (r_state != ST_RUN) || w_tc || w_halt_rise || !bus.run_req;

  // Tick decode: terminal counts pass only while RUN is not being left.
  always_comb begin
    w_tick = 1'b0;
    case (r_state)
      ST_RUN:  w_tick = w_tc && !w_halt_rise && bus.run_req;
      ST_STEP: w_tick = 1'b1;
      default: w_tick = 1'b0;
    endcase
  end

  // Divider counter, running only in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Previous halt_in level for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_halt_q <= 1'b0;
    end else begin
      r_halt_q <= bus.halt_in;
    end
  end

  // Run/halt/step state machine; r_ret remembers where a step returns to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ret   <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.run_req) begin
            r_state <= ST_RUN;
          end else if (w_step_pulse) begin
            r_state <= ST_STEP;
            r_ret   <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_halt_rise) begin
            r_state <= ST_HALT;
          end else if (!bus.run_req) begin
            r_state <= ST_IDLE;
          end
        end
        ST_HALT: begin
          if (bus.resume) begin
            r_state <= bus.run_req ? ST_RUN : ST_IDLE;
          end else if (w_step_pulse) begin
            r_state <= ST_STEP;
            r_ret   <= ST_HALT;
          end
        end
        ST_STEP: begin
          r_state <= r_ret;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Visible slow clock and wrapping tick counter, both advanced by each tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led        <= 1'b0;
      r_tick_count <= '0;
    end else if (w_tick) begin
      r_led        <= ~r_led;
      r_tick_count <= r_tick_count + 1'b1;
    end
  end

  assign bus.cpu_tick    = w_tick;
  assign bus.cpu_clk_led = r_led;
  assign bus.state       = r_state;
  assign bus.tick_count  = r_tick_count;
endmodule
`default_nettype wire
